vga_hs_monitor: RTL and testbench
=================================

// Module: vga_hs_monitor
// PURPOSE
//  Receive-side counterpart of the VGA HS timing generator. Samples an asynchronous
//  HS input, measures line period, sync pulse width and sync polarity, and reports
//  lock once the line timing is stable. Used as a loopback checker on generator
//  outputs and as a mode detector on incoming video.
// PARAMETERS
//  CNT_W       13    run-length counter width; also the no-edge timeout is 2**CNT_W-1 clk
//  LOCK_LINES  4     consecutive in-tolerance periods required to assert locked (>=1)
//  TOL         2     max |period - previous period| in clk cycles counted as a match
// PORTS
//  clk         in   1        system clock
//  rst_n       in   1        synchronous, active-low reset
//  hs_in       in   1        HS from pin/generator, asynchronous to clk
//  period      out  CNT_W+1  last measured line period, clk cycles, rising edge to rising edge
//  pulse_w     out  CNT_W    last measured sync pulse width (the shorter phase)
//  pol         out  1        1 = active-high sync pulse, 0 = active-low
//  meas_valid  out  1        1-clk strobe when period/pulse_w/pol update
//  locked      out  1        line timing is stable
//  lock_lost   out  1        1-clk strobe on any LOCKED -> not-locked transition
// BEHAVIOUR
//  - Reset: all outputs 0, sync registers 0, FSM = IDLE, counters 0, have_high = 0.
//  - Sync: 2-FF synchronizer s1->s2, plus s3 delay. rise = s2&~s3, fall = ~s2&s3.
//  - Run counter: loads 1 on rise/fall, else increments, saturates at 2**CNT_W-1.
//  - fall: high_len <= run counter, have_high <= 1.
//  - rise with have_high=1: measurement completes on that same clk edge.
//    * p = high_len + low_len, where low_len = run counter.
//    * period <= p; pol <= (high_len <= low_len), so a tie gives pol = 1.
//    * pulse_w <= min(high_len, low_len).
//    * meas_valid = 1 for one cycle.
//    * Outputs are visible 3 clk edges after hs_in rising is first sampled.
//  - rise with have_high=0 (first edge after IDLE): no measurement.
//  - FSM IDLE / ACQ / LOCKED. A match means |p - ref| <= TOL; ref <= p on every
//    measurement. mcnt is a match counter, 0..LOCK_LINES.
//    * IDLE: first measurement -> ACQ, mcnt = 0.
//    * ACQ: match -> mcnt++, else mcnt = 0. When mcnt reaches LOCK_LINES -> LOCKED,
//      and locked = 1 on that same edge.
//    * LOCKED: match -> stay. Mismatch -> ACQ, mcnt = 0, locked = 0, lock_lost strobe.
//  - Timeout: run counter saturated with no edge, from any state.
//    * FSM -> IDLE, have_high = 0.
//    * period, pulse_w, pol, locked cleared to 0.
//    * lock_lost strobes only if the previous state was LOCKED. Fires once, not every
//      saturated cycle.
//  - Width rule: saturated runs are never used in a measurement. A run reaching
//    saturation forces timeout.
//  - A glitch shorter than 2 clk may be lost by the synchronizer. This is accepted; no
//    filtering is done.
//  - Reset asserted mid-operation: outputs return to reset values on the next clk edge.
//    The strobe in progress is dropped.
// TESTING
//  1 rst_n=0 for 5 clk, hs_in toggling -> all outputs 0, no meas_valid during reset.
//  2 hs_in low 10 clk / high 990 clk / low 600 (period 1600) -> period=1600, pulse_w=610,
//    pol=0; locked rises with the 5th meas_valid (LOCK_LINES=4).
//  3 Active-high 96 clk pulse, period 800 -> pol=1, pulse_w=96, period=800, locked.
//  4 Locked at 1600: periods 1601, 1599 keep locked=1. A 1700 period gives lock_lost=1
//    for 1 clk and locked=0; relock after 4 further 1700 periods.
//  5 Locked, then hs_in held high for 8191 clk -> one lock_lost strobe; period, pulse_w,
//    pol, locked = 0; FSM returns to IDLE.
//  6 Equal phases 500/500 -> pol=1, pulse_w=500. rst_n pulsed low mid-line -> outputs 0,
//    then relock after reset releases.

Source files
------------

// File: rtl/vga_hs_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : vga_hs_monitor
//  Description : Receive-side HS timing monitor. Synchronises an asynchronous
//                HS input, measures the line period (rising edge to rising
//                edge), the sync pulse width (the shorter of the two phases)
//                and the sync polarity, and reports lock once consecutive
//                line periods agree within a tolerance.
//  Ports       : clk        - system clock
//                rst_n      - synchronous, active-low reset
//                hs_in      - HS input, asynchronous to clk
//                period     - last measured line period in clk cycles
//                pulse_w    - last measured sync pulse width in clk cycles
//                pol        - 1 = active-high sync, 0 = active-low sync
//                meas_valid - 1-clk strobe when period/pulse_w/pol update
//                locked     - line timing is stable
//                lock_lost  - 1-clk strobe when lock is dropped
//  Revision    : 1.0  initial release
// ============================================================================
module vga_hs_monitor #(
    parameter int CNT_W      = 13,
    parameter int LOCK_LINES = 4,
    parameter int TOL        = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hs_in,
    output logic [CNT_W:0]   period,
    output logic [CNT_W-1:0] pulse_w,
    output logic             pol,
    output logic             meas_valid,
    output logic             locked,
    output logic             lock_lost
);

    localparam int              MCNT_W    = $clog2(LOCK_LINES + 1);
    localparam logic [CNT_W-1:0] C_RUN_MAX = '1;
    localparam logic [CNT_W:0]   C_TOL     = (CNT_W + 1)'(TOL);
    localparam logic [MCNT_W-1:0] C_LOCK   = MCNT_W'(LOCK_LINES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_s1;
    logic              r_s2;
    logic              r_s3;
    logic [CNT_W-1:0]  r_run;
    logic [CNT_W-1:0]  r_high_len;
    logic              r_have_high;
    logic [CNT_W:0]    r_ref;
    logic [MCNT_W-1:0] r_mcnt;

    logic              w_rise;
    logic              w_fall;
    logic              w_edge;
    logic              w_timeout;
    logic              w_measure;
    logic [CNT_W:0]    w_p;
    logic [CNT_W:0]    w_diff;
    logic              w_match;
    logic              w_pol;
    logic [CNT_W-1:0]  w_pw;
    logic [MCNT_W-1:0] w_mcnt_inc;

    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;
    assign w_edge = w_rise | w_fall;

    // A saturated run counter means the current phase is too long to be a
    // valid line. This takes priority over an edge arriving on the same
    // cycle so that a saturated run is never folded into a measurement.
    assign w_timeout = (r_run == C_RUN_MAX);

    // On a rising edge r_run holds the low-phase length just ended.
    assign w_measure  = w_rise & r_have_high & ~w_timeout;
    assign w_p        = {1'b0, r_high_len} + {1'b0, r_run};
    assign w_diff     = (w_p >= r_ref) ? (w_p - r_ref) : (r_ref - w_p);
    assign w_match    = (w_diff <= C_TOL);
    // Equal phases resolve to active-high.
    assign w_pol      = (r_high_len <= r_run);
    assign w_pw       = w_pol ? r_high_len : r_run;
    assign w_mcnt_inc = r_mcnt + MCNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_run       <= '0;
            r_high_len  <= '0;
            r_have_high <= 1'b0;
            r_ref       <= '0;
            r_mcnt      <= '0;
            r_state     <= ST_IDLE;
            period      <= '0;
            pulse_w     <= '0;
            pol         <= 1'b0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            r_s1       <= hs_in;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            meas_valid <= 1'b0;
            lock_lost  <= 1'b0;

            // Run-length counter: restarts at 1 on every edge, saturates.
            if (w_edge) begin
                r_run <= CNT_W'(1);
            end else if (!w_timeout) begin
                r_run <= r_run + CNT_W'(1);
            end

            if (w_fall) begin
                r_high_len <= r_run;
            end

            if (w_timeout) begin
                // Repeats every saturated cycle; lock_lost only fires on the
                // first one because the state has already left LOCKED.
                r_have_high <= 1'b0;
                r_state     <= ST_IDLE;
                r_mcnt      <= '0;
                period      <= '0;
                pulse_w     <= '0;
                pol         <= 1'b0;
                locked      <= 1'b0;
                lock_lost   <= (r_state == ST_LOCKED);
            end else begin
                if (w_fall) begin
                    r_have_high <= 1'b1;
                end
                if (w_measure) begin
                    period     <= w_p;
                    pulse_w    <= w_pw;
                    pol        <= w_pol;
                    meas_valid <= 1'b1;
                    r_ref      <= w_p;
                    case (r_state)
                        ST_IDLE: begin
                            r_state <= ST_ACQ;
                            r_mcnt  <= '0;
                        end
                        ST_ACQ: begin
                            if (w_match) begin
                                r_mcnt <= w_mcnt_inc;
                                if (w_mcnt_inc == C_LOCK) begin
                                    r_state <= ST_LOCKED;
                                    locked  <= 1'b1;
                                end
                            end else begin
                                r_mcnt <= '0;
                            end
                        end
                        ST_LOCKED: begin
                            if (!w_match) begin
                                r_state   <= ST_ACQ;
                                r_mcnt    <= '0;
                                locked    <= 1'b0;
                                lock_lost <= 1'b1;
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_mcnt  <= '0;
                            locked  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_hs_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_hs_monitor
//  Description : Self-checking bench for vga_hs_monitor. A cycle-indexed
//                behavioural model (edge timestamps, plain arithmetic) is
//                compared against every DUT output on every cycle, and a set
//                of hand-computed expectations pins the model at key points.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_hs_monitor;

    localparam int CNT_W      = 13;
    localparam int LOCK_LINES = 4;
    localparam int TOL        = 2;
    localparam int RUN_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             hs_in;
    logic [CNT_W:0]   period;
    logic [CNT_W-1:0] pulse_w;
    logic             pol;
    logic             meas_valid;
    logic             locked;
    logic             lock_lost;

    int checks = 0;
    int errors = 0;
    int printed = 0;

    vga_hs_monitor #(
        .CNT_W      (CNT_W),
        .LOCK_LINES (LOCK_LINES),
        .TOL        (TOL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hs_in      (hs_in),
        .period     (period),
        .pulse_w    (pulse_w),
        .pol        (pol),
        .meas_valid (meas_valid),
        .locked     (locked),
        .lock_lost  (lock_lost)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model. Edge n is the n-th rising clock edge. The HS level
    // seen by the edge detector at edge n is the input sampled two edges
    // earlier, so an input transition is registered as an edge event at
    // edge n when sample[n-2] != sample[n-3]. A run length is the number of
    // edges since the previous event.
    // ------------------------------------------------------------------
    int   n         = 0;
    bit   hist [4];
    int   last_edge = 1;
    int   high_len  = 0;
    bit   have_high = 1'b0;
    int   ref_p     = 0;
    int   mcnt      = 0;
    int   mode      = 0;     // 0 idle, 1 acquiring, 2 locked
    int   e_period  = 0;
    int   e_pw      = 0;
    bit   e_pol     = 1'b0;
    bit   e_mv      = 1'b0;
    bit   e_locked  = 1'b0;
    bit   e_ll      = 1'b0;
    int   ll_cnt    = 0;

    always @(posedge clk) begin
        bit now_s;
        bit old_s;
        int len;
        int p;
        int d;
        hist[n % 4] = hs_in;
        e_mv = 1'b0;
        e_ll = 1'b0;
        if (!rst_n) begin
            hist[n % 4]       = 1'b0;
            hist[(n + 3) % 4] = 1'b0;
            hist[(n + 2) % 4] = 1'b0;
            last_edge = n + 1;
            high_len  = 0;
            have_high = 1'b0;
            ref_p     = 0;
            mcnt      = 0;
            mode      = 0;
            e_period  = 0;
            e_pw      = 0;
            e_pol     = 1'b0;
            e_locked  = 1'b0;
        end else begin
            now_s = hist[(n + 2) % 4];
            old_s = hist[(n + 1) % 4];
            len   = n - last_edge;
            if (len > RUN_MAX) len = RUN_MAX;
            if (now_s != old_s) last_edge = n;
            if (len == RUN_MAX) begin
                if (mode == 2) e_ll = 1'b1;
                mode      = 0;
                mcnt      = 0;
                have_high = 1'b0;
                e_period  = 0;
                e_pw      = 0;
                e_pol     = 1'b0;
                e_locked  = 1'b0;
            end else if (!now_s && old_s) begin
                high_len  = len;
                have_high = 1'b1;
            end else if (now_s && !old_s && have_high) begin
                p        = high_len + len;
                d        = (p > ref_p) ? p - ref_p : ref_p - p;
                ref_p    = p;
                e_period = p;
                e_pol    = (high_len <= len);
                e_pw     = e_pol ? high_len : len;
                e_mv     = 1'b1;
                if (mode == 0) begin
                    mode = 1;
                    mcnt = 0;
                end else if (mode == 1) begin
                    if (d <= TOL) begin
                        mcnt++;
                        if (mcnt == LOCK_LINES) begin
                            mode     = 2;
                            e_locked = 1'b1;
                        end
                    end else begin
                        mcnt = 0;
                    end
                end else if (d > TOL) begin
                    mode     = 1;
                    mcnt     = 0;
                    e_locked = 1'b0;
                    e_ll     = 1'b1;
                end
            end
        end
        n++;
        #2;
        checks++;
        if (period !== (CNT_W + 1)'(e_period) || pulse_w !== CNT_W'(e_pw) ||
            pol !== e_pol || meas_valid !== e_mv || locked !== e_locked ||
            lock_lost !== e_ll) begin
            errors++;
            if (printed < 30) begin
                printed++;
                $display("FAIL cycle%0d: got per=%0d pw=%0d pol=%b mv=%b lk=%b ll=%b expected per=%0d pw=%0d pol=%b mv=%b lk=%b ll=%b",
                         n, period, pulse_w, pol, meas_valid, locked, lock_lost,
                         e_period, e_pw, e_pol, e_mv, e_locked, e_ll);
            end
        end
        if (lock_lost === 1'b1) ll_cnt++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge)
    // ------------------------------------------------------------------
    task automatic hold(input bit v, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            hs_in = v;
            @(negedge clk);
        end
    endtask

    // One line: 'lvl' for pw cycles, then the opposite level for the rest.
    task automatic line(input bit lvl, input int pw, input int total);
        hold(lvl, pw);
        hold(~lvl, total - pw);
    endtask

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic lit_zero(input string tag);
        lit({tag, " period"},  int'(period), 0);
        lit({tag, " pulse_w"}, int'(pulse_w), 0);
        lit({tag, " pol"},     int'(pol), 0);
        lit({tag, " locked"},  int'(locked), 0);
    endtask

    initial begin
        int ll0;
        int base;
        int pw;
        rst_n = 1'b0;
        hs_in = 1'b0;
        @(negedge clk);

        // Reset with a toggling input
        for (int i = 0; i < 5; i++) hold(i[0], 1);
        lit_zero("reset");
        lit("reset meas_valid", int'(meas_valid), 0);
        rst_n = 1'b1;

        // Active-low sync: low 610, high 990, period 1600
        for (int i = 0; i < 8; i++) line(1'b0, 610, 1600);
        lit("al period",  int'(period), 1600);
        lit("al pulse_w", int'(pulse_w), 610);
        lit("al pol",     int'(pol), 0);
        lit("al locked",  int'(locked), 1);

        // Active-high sync: 96 high, period 800
        for (int i = 0; i < 8; i++) line(1'b1, 96, 800);
        lit("ah period",  int'(period), 800);
        lit("ah pulse_w", int'(pulse_w), 96);
        lit("ah pol",     int'(pol), 1);
        lit("ah locked",  int'(locked), 1);

        // Jitter within tolerance keeps lock; a large step drops it
        for (int i = 0; i < 8; i++) line(1'b0, 610, 1600);
        lit("relock 1600", int'(locked), 1);
        line(1'b0, 610, 1601);
        line(1'b0, 610, 1599);
        lit("jitter +1 period", int'(period), 1601);
        lit("jitter +1 locked", int'(locked), 1);
        ll0 = ll_cnt;
        line(1'b0, 610, 1700);
        lit("jitter -2 period", int'(period), 1599);
        lit("jitter -2 locked", int'(locked), 1);
        lit("jitter no lost",   ll_cnt, ll0);
        line(1'b0, 610, 1700);
        lit("step period",    int'(period), 1700);
        lit("step locked",    int'(locked), 0);
        lit("step lock_lost", ll_cnt, ll0 + 1);
        for (int i = 0; i < 4; i++) line(1'b0, 610, 1700);
        lit("step relock", int'(locked), 1);

        // Timeout: HS stuck high
        ll0 = ll_cnt;
        hold(1'b1, 8300);
        lit_zero("timeout");
        lit("timeout lock_lost once", ll_cnt, ll0 + 1);
        hold(1'b0, 100);

        // Equal phases, then reset mid-line
        for (int i = 0; i < 8; i++) line(1'b1, 500, 1000);
        lit("tie period",  int'(period), 1000);
        lit("tie pulse_w", int'(pulse_w), 500);
        lit("tie pol",     int'(pol), 1);
        lit("tie locked",  int'(locked), 1);
        hold(1'b1, 250);
        rst_n = 1'b0;
        hold(1'b1, 3);
        lit_zero("midreset");
        lit("midreset meas_valid", int'(meas_valid), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) line(1'b1, 500, 1000);
        lit("post-reset locked", int'(locked), 1);

        // Randomised lines with jitter around a random base period
        for (int blk = 0; blk < 3; blk++) begin
            base = $urandom_range(200, 400);
            for (int i = 0; i < 7; i++) begin
                pw = $urandom_range(20, 80);
                line(blk[0], pw, base + $urandom_range(0, 4) - 2);
            end
        end
        hold(1'b0, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
